// File: rtl/adder_accum_seq.sv
// Operand feeder and running-sum accumulator wrapped around an external 6-bit combinational adder.
// Optional saturation of the running sum: define ADDER_ACCUM_SAT_EN.
module adder_accum_seq #(
    parameter int unsigned MAX_TERMS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    input  logic       in_last,
    output logic [5:0] add_x,
    output logic [5:0] add_y,
    input  logic [5:0] add_s,
    input  logic       add_ov,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [5:0] res_data,
    output logic       res_ovf,
    output logic       res_trunc
);

    localparam int unsigned DW = 6;
    localparam int unsigned CW = $clog2(MAX_TERMS + 1);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ADD    = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   acc, acc_next;
    logic [DW-1:0]   op, op_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            ovf, ovf_next;
    logic            trunc, trunc_next;
    logic            last_q, last_next;

    // State and datapath registers; handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCEPT;
            acc       <= '0;
            op        <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            trunc     <= 1'b0;
            last_q    <= 1'b0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            op        <= op_next;
            cnt       <= cnt_next;
            ovf       <= ovf_next;
            trunc     <= trunc_next;
            last_q    <= last_next;
            in_ready  <= (state_next == ACCEPT);
            res_valid <= (state_next == DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        acc_next   = acc;
        op_next    = op;
        cnt_next   = cnt;
        ovf_next   = ovf;
        trunc_next = trunc;
        last_next  = last_q;
        case (state)
            ACCEPT: begin
                if (in_valid && in_ready) begin
                    op_next    = in_data;
                    last_next  = in_last;
                    state_next = ADD;
                end
            end
            ADD: begin
`ifdef ADDER_ACCUM_SAT_EN
                acc_next = (add_ov || ovf) ? {DW{1'b1}} : add_s;
`else
                acc_next = add_s;
`endif
                ovf_next = ovf | add_ov;
                cnt_next = cnt + CW'(1);
                if (last_q) begin
                    state_next = DONE;
                end else if (cnt == CW'(MAX_TERMS - 1)) begin
                    trunc_next = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = ACCEPT;
                end
            end
            DONE: begin
                if (res_ready) begin
                    acc_next   = '0;
                    op_next    = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    trunc_next = 1'b0;
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    assign add_x     = acc;
    assign add_y     = op;
    assign res_data  = acc;
    assign res_ovf   = ovf;
    assign res_trunc = trunc;

endmodule

// File: doc/adder_accum_seq.md
# adder_accum_seq

Sequential operand feeder and result accumulator for the 6-bit parallel-prefix `adder` block.
- Accepts a stream of 6-bit operands over a valid/ready handshake.
- Drives the adder's `x`/`y` inputs from registers and captures the adder's `s`/`ov` outputs back into a running sum.
- Returns one accumulated result per operand group to a downstream consumer.
- The adder itself stays purely combinational and is instantiated beside this block; this block owns all state around it.

## Interface
Parameters:
- `MAX_TERMS`, default 8: maximum operands per group; range 2..16.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand present.
- `in_ready` output 1: block can accept an operand this cycle.
- `in_data` input 6: operand, unsigned.
- `in_last` input 1: this operand closes the group.
- `add_x` output 6: to adder `x5..x0`; always equals accumulator register `acc`.
- `add_y` output 6: to adder `y5..y0`; always equals operand register `op`.
- `add_s` input 6: from adder `s5..s0`.
- `add_ov` input 1: from adder `ov` (carry out of bit 5).
- `res_valid` output 1: group result available.
- `res_ready` input 1: consumer accepts result.
- `res_data` output 6: accumulated sum.
- `res_ovf` output 1: sticky carry-out for the group.
- `res_trunc` output 1: group was closed by `MAX_TERMS`, not by `in_last`.

## Operation
- The block has three states: ACCEPT, ADD and DONE.
- **Reset:** state = ACCEPT; `acc`, `op`, the term counter `cnt`, `ovf`, `trunc` and `last_q` all = 0.
  - Outputs after reset: `in_ready`=1, `res_valid`=0, `res_data`=0, `res_ovf`=0, `res_trunc`=0, `add_x`=0, `add_y`=0.
- **ACCEPT:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: `op` <= `in_data`, `last_q` <= `in_last`, go to ADD.
  - Otherwise the block holds its state.
- **ADD:**
  - `in_ready`=0.
  - `acc` <= `add_s`; `ovf` <= `ovf | add_ov`; `cnt` <= `cnt`+1.
  - If `last_q`=1: go to DONE.
  - Else if `cnt` == `MAX_TERMS`-1: set `trunc`, go to DONE.
  - Else: go to ACCEPT.
- **DONE:**
  - `res_valid`=1; `res_data`=`acc`, `res_ovf`=`ovf`, `res_trunc`=`trunc`. These hold stable while `res_ready`=0.
  - `in_ready`=0.
  - On `res_ready`: clear `acc`, `op`, `cnt`, `ovf` and `trunc`, then go to ACCEPT.
- **Arithmetic:** unsigned modulo 2^6; `add_ov` is the carry out of bit 5. Signed overflow is not computed.
- **Boundary rules:**
  - A single-operand group (`in_last` on the first operand) gives `res_data` = operand, because `acc` = 0.
  - If `in_last` arrives on term `MAX_TERMS`, `trunc` stays 0.
  - When `trunc` fires, the next operand starts a new group.
  - `in_valid` asserted while `in_ready`=0 is ignored. The upstream must hold its data until the handshake completes.
  - Asserting `rst_n` low in any state aborts the group immediately. The partial sum is discarded and no result is emitted.

## Timing
- Per operand: 2 cycles, accept then ADD. Sustained rate is one operand every 2 cycles.
- The adder path is combinational within one cycle: from the `op`/`acc` registers, through `add_y`/`add_x`, through the adder, to `add_s`, and into `acc`.
- Result latency: `res_valid` rises 1 cycle after the ADD cycle of the closing operand, i.e. 2 cycles after that operand's handshake.
- Consumer handshake: `res_valid` does not depend on `res_ready`. Once `res_valid` rises, the result is held until `res_ready`.
- Turnaround: the earliest next operand handshake is the cycle after `res_ready` is sampled high.

## Configuration
- Macro `ADDER_ACCUM_SAT_EN`.
- **Defined:** in ADD, if `add_ov`=1 or `ovf`=1, then `acc` <= 6'h3F. The sum saturates and stays at 6'h3F for the rest of the group; `res_ovf` is still reported.
- **Undefined:** `acc` always takes `add_s` (wrap-around); `res_ovf` is the only overflow indication.

## Test plan
- Reset check: hold `rst_n` low, then release → `in_ready`=1, `res_valid`=0, `add_x`=0, `add_y`=0.
- Three-operand group 5, 10, 20 (`in_last` on 20) → `res_data`=35, `res_ovf`=0, `res_trunc`=0; `res_valid` rises 2 cycles after the last accept.
- Overflow: group 40, 30 with `in_last` → `res_ovf`=1.
  - `ADDER_ACCUM_SAT_EN` undefined: `res_data`=6.
  - `ADDER_ACCUM_SAT_EN` defined: `res_data`=63.
- Truncation with `MAX_TERMS`=8: eight operands of 1, none with `in_last` → `res_data`=8, `res_trunc`=1. A ninth operand of 3 with `in_last` → the next result is `res_data`=3, `res_trunc`=0.
- Back-pressure: hold `res_ready`=0 for 5 cycles in DONE while `in_valid`=1 → `res_*` stable, `in_ready`=0, no operand consumed. Raise `res_ready` → the next operand is accepted the following cycle.
- Reset mid-group: accept 7, then pull `rst_n` low during ADD → all registers 0 immediately and no result is emitted. The next group, 2 with `in_last`, gives `res_data`=2.
